// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Operand forwarding and pipeline hazard detection for the ID stage of the
// five-stage MIPS core. Each ID read port takes its operand from the youngest
// in-flight producer (EX, then MEM) or falls back to the register file. Stalls
// are raised for load-use hazards and for HI/LO reads that would race an
// in-flight multiply/divide.
//
// Parameters:
//   NRP    number of ID-stage register read ports
//   DW     datapath width
//   MDLAT  mul/div result latency in cycles (1..15)
//
// Configuration macro:
//   FWD_DMOUT_EN  when defined, a load sitting in MEM forwards dmout_mem
//                 directly; when undefined, it stalls ID for one more cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rd_en_id/addr/data       per-port read enable, address (5 bits/port),
//                            register file read data (DW bits/port)
//   rw_ex, rw_mem            destination register of EX / MEM instruction
//   din_sel_ex, din_sel_mem  writeback source code of EX / MEM instruction
//   alu_r_*, cp0_*, pc_*,
//   hilo_*, dmout_mem        candidate forward values (HI in hilo upper half)
//   md_start_ex              mul/div enters EX this cycle
//   hilo_rd_id               ID instruction reads HI/LO
//   fwd_data_id              resolved operands, combinational
//   stall_id                 freeze IF/ID
//   md_busy                  mul/div in flight (registered)
//   stall_cnt                saturating count of stalled cycles
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
   parameter int NRP   = 2,
   parameter int DW    = 32,
   parameter int MDLAT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NRP-1:0]    rd_en_id,
   input  logic [5*NRP-1:0]  rd_addr_id,
   input  logic [DW*NRP-1:0] rd_data_id,
   input  logic [4:0]        rw_ex,
   input  logic [4:0]        rw_mem,
   input  logic [2:0]        din_sel_ex,
   input  logic [2:0]        din_sel_mem,
   input  logic [DW-1:0]     alu_r_ex,
   input  logic [DW-1:0]     alu_r_mem,
   input  logic [DW-1:0]     cp0_ex,
   input  logic [DW-1:0]     cp0_mem,
   input  logic [DW-1:0]     dmout_mem,
   input  logic [31:0]       pc_ex,
   input  logic [31:0]       pc_mem,
   input  logic [2*DW-1:0]   hilo_ex,
   input  logic [2*DW-1:0]   hilo_mem,
   input  logic              md_start_ex,
   input  logic              hilo_rd_id,
   output logic [DW*NRP-1:0] fwd_data_id,
   output logic              stall_id,
   output logic              md_busy,
   output logic [31:0]       stall_cnt
);

   localparam logic [2:0] SEL_PC8   = 3'b001;
   localparam logic [2:0] SEL_DMOUT = 3'b010;
   localparam logic [2:0] SEL_CP0   = 3'b011;
   localparam logic [2:0] SEL_HI    = 3'b100;
   localparam logic [2:0] SEL_LO    = 3'b101;
   localparam logic [2:0] SEL_ALU   = 3'b110;

   logic [3:0]     md_cnt;
   logic [3:0]     md_cnt_next;
   logic [DW-1:0]  ex_val;
   logic [DW-1:0]  mem_val;
   logic           ex_fwd_ok;
   logic           mem_fwd_ok;
   logic [NRP-1:0] hit_ex;
   logic [NRP-1:0] hit_mem;
   logic [NRP-1:0] load_use_ex;
   logic [NRP-1:0] load_use_mem;

   // Value a stage would write back, selected by its source code. The return
   // address is truncated or zero-extended to the datapath width.
   function automatic logic [DW-1:0] stage_value(
      input logic [2:0]      sel,
      input logic [DW-1:0]   alu,
      input logic [DW-1:0]   cp0,
      input logic [DW-1:0]   dmout,
      input logic [31:0]     pc,
      input logic [2*DW-1:0] hilo
   );
      logic [31:0] pc8;
      pc8 = pc + 32'd8;
      case (sel)
         SEL_ALU:   return alu;
         SEL_PC8:   return DW'(pc8);
         SEL_DMOUT: return dmout;
         SEL_CP0:   return cp0;
         SEL_HI:    return hilo[2*DW-1:DW];
         SEL_LO:    return hilo[DW-1:0];
         default:   return '0;
      endcase
   endfunction

   // Candidate values per stage and whether the stage's source code is one we
   // may forward. A load in EX has no data yet, so EX never forwards 010. A
   // load in MEM forwards only when the dmout bypass is built in.
   always_comb begin
      ex_val    = stage_value(din_sel_ex, alu_r_ex, cp0_ex, '0, pc_ex, hilo_ex);
      mem_val   = stage_value(din_sel_mem, alu_r_mem, cp0_mem, dmout_mem, pc_mem, hilo_mem);
      ex_fwd_ok = din_sel_ex inside {SEL_ALU, SEL_PC8, SEL_CP0, SEL_HI, SEL_LO};
`ifdef FWD_DMOUT_EN
      mem_fwd_ok = din_sel_mem inside {SEL_ALU, SEL_PC8, SEL_DMOUT, SEL_CP0, SEL_HI, SEL_LO};
`else
      mem_fwd_ok = din_sel_mem inside {SEL_ALU, SEL_PC8, SEL_CP0, SEL_HI, SEL_LO};
`endif
   end

   // Per-port match and operand selection. EX is younger than MEM, so it wins.
   // A MEM load hazard only matters when EX is not already supplying the port.
   always_comb begin
      fwd_data_id  = rd_data_id;
      hit_ex       = '0;
      hit_mem      = '0;
      load_use_ex  = '0;
      load_use_mem = '0;
      for (int i = 0; i < NRP; i++) begin
         hit_ex[i]      = rd_en_id[i] && (rd_addr_id[5*i +: 5] == rw_ex)  && (rw_ex  != 5'd0);
         hit_mem[i]     = rd_en_id[i] && (rd_addr_id[5*i +: 5] == rw_mem) && (rw_mem != 5'd0);
         load_use_ex[i] = hit_ex[i] && (din_sel_ex == SEL_DMOUT);
`ifndef FWD_DMOUT_EN
         load_use_mem[i] = hit_mem[i] && (din_sel_mem == SEL_DMOUT) && !(hit_ex[i] && ex_fwd_ok);
`endif
         if (hit_ex[i] && ex_fwd_ok) begin
            fwd_data_id[DW*i +: DW] = ex_val;
         end else if (hit_mem[i] && mem_fwd_ok) begin
            fwd_data_id[DW*i +: DW] = mem_val;
         end
      end
   end

   // All stall causes collapse into one signal; reset masks it.
   always_comb begin
      stall_id = !rst && ((|load_use_ex) || (|load_use_mem) ||
                          (hilo_rd_id && (md_busy || md_start_ex)));
   end

   // Mul/div countdown. A new start always reloads the full latency, even if
   // an earlier operation is still counting.
   always_comb begin
      if (md_start_ex) begin
         md_cnt_next = 4'(MDLAT);
      end else if (md_cnt != 4'd0) begin
         md_cnt_next = md_cnt - 4'd1;
      end else begin
         md_cnt_next = md_cnt;
      end
   end

   // md_busy is registered from the next count so it tracks md_cnt exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         md_cnt  <= 4'd0;
         md_busy <= 1'b0;
      end else begin
         md_cnt  <= md_cnt_next;
         md_busy <= (md_cnt_next != 4'd0);
      end
   end

   // Stall statistics, saturating rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= 32'd0;
      end else if (stall_id && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
//
// Directed bench for fwd_hazard_unit (NRP=2, DW=32, MDLAT=4). Each cycle the
// stimulus process drives one vector and queues the hand-computed response;
// a monitor on the falling edge pops and compares. Honours FWD_DMOUT_EN the
// same way the design does.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

   localparam logic [31:0] RD0 = 32'hDDDD_0000;
   localparam logic [31:0] RD1 = 32'hDDDD_0001;

   logic        clk;
   logic        rst;
   logic [1:0]  rd_en_id;
   logic [9:0]  rd_addr_id;
   logic [63:0] rd_data_id;
   logic [4:0]  rw_ex;
   logic [4:0]  rw_mem;
   logic [2:0]  din_sel_ex;
   logic [2:0]  din_sel_mem;
   logic [31:0] alu_r_ex;
   logic [31:0] alu_r_mem;
   logic [31:0] cp0_ex;
   logic [31:0] cp0_mem;
   logic [31:0] dmout_mem;
   logic [31:0] pc_ex;
   logic [31:0] pc_mem;
   logic [63:0] hilo_ex;
   logic [63:0] hilo_mem;
   logic        md_start_ex;
   logic        hilo_rd_id;
   logic [63:0] fwd_data_id;
   logic        stall_id;
   logic        md_busy;
   logic [31:0] stall_cnt;

   typedef struct {
      string       name;
      bit          chk_f0;
      bit          chk_f1;
      logic [31:0] f0;
      logic [31:0] f1;
      logic        stall;
      logic        busy;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb_q[$];
   int          checks;
   int          errors;
   logic [31:0] exp_cnt;

   fwd_hazard_unit #(.NRP(2), .DW(32), .MDLAT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .rd_en_id    (rd_en_id),
      .rd_addr_id  (rd_addr_id),
      .rd_data_id  (rd_data_id),
      .rw_ex       (rw_ex),
      .rw_mem      (rw_mem),
      .din_sel_ex  (din_sel_ex),
      .din_sel_mem (din_sel_mem),
      .alu_r_ex    (alu_r_ex),
      .alu_r_mem   (alu_r_mem),
      .cp0_ex      (cp0_ex),
      .cp0_mem     (cp0_mem),
      .dmout_mem   (dmout_mem),
      .pc_ex       (pc_ex),
      .pc_mem      (pc_mem),
      .hilo_ex     (hilo_ex),
      .hilo_mem    (hilo_mem),
      .md_start_ex (md_start_ex),
      .hilo_rd_id  (hilo_rd_id),
      .fwd_data_id (fwd_data_id),
      .stall_id    (stall_id),
      .md_busy     (md_busy),
      .stall_cnt   (stall_cnt)
   );

   // 10 ns clock, first rising edge at 5 ns.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Quiet default vector with distinctive values on every candidate bus.
   task automatic setDefaults();
      rst         = 1'b0;
      rd_en_id    = 2'b00;
      rd_addr_id  = '0;
      rd_data_id  = {RD1, RD0};
      rw_ex       = 5'd0;
      rw_mem      = 5'd0;
      din_sel_ex  = 3'b000;
      din_sel_mem = 3'b000;
      alu_r_ex    = 32'hA1A1_A1A1;
      alu_r_mem   = 32'hA2A2_A2A2;
      cp0_ex      = 32'hC1C1_C1C1;
      cp0_mem     = 32'hC2C2_C2C2;
      dmout_mem   = 32'hD3D3_D3D3;
      pc_ex       = 32'h0000_1000;
      pc_mem      = 32'h0000_2000;
      hilo_ex     = 64'h0;
      hilo_mem    = 64'h0;
      md_start_ex = 1'b0;
      hilo_rd_id  = 1'b0;
   endtask

   // Move to the next cycle, just after the rising edge, and reset inputs.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      setDefaults();
   endtask

   // Queue the response for the current vector and advance the stall-count
   // model to the value expected after the coming edge.
   task automatic expectOutput(input string name, input bit cf0, input logic [31:0] f0,
                               input bit cf1, input logic [31:0] f1,
                               input logic stall, input logic busy);
      exp_t e;
      e.name   = name;
      e.chk_f0 = cf0;
      e.chk_f1 = cf1;
      e.f0     = f0;
      e.f1     = f1;
      e.stall  = stall;
      e.busy   = busy;
      e.cnt    = exp_cnt;
      sb_q.push_back(e);
      if (rst) exp_cnt = 32'd0;
      else if (stall) exp_cnt = exp_cnt + 32'd1;
   endtask

   task automatic checkOutput(input string name, input string field,
                              input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s.%s actual=%h expected=%h", name, field, actual, expected);
      end
   endtask

   // Monitor: compare the oldest queued expectation at every falling edge.
   initial begin : monitor
      exp_t cur;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            if (cur.chk_f0) checkOutput(cur.name, "port0", fwd_data_id[31:0], cur.f0);
            if (cur.chk_f1) checkOutput(cur.name, "port1", fwd_data_id[63:32], cur.f1);
            checkOutput(cur.name, "stall_id", {31'd0, stall_id}, {31'd0, cur.stall});
            checkOutput(cur.name, "md_busy", {31'd0, md_busy}, {31'd0, cur.busy});
            checkOutput(cur.name, "stall_cnt", stall_cnt, cur.cnt);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin : stimulus
      checks  = 0;
      errors  = 0;
      exp_cnt = 32'd0;
      setDefaults();
      rst = 1'b1;

      // Reset: forwarding still follows inputs, stall masked, md_start ignored.
      applyStimulus();
      rst = 1'b1; md_start_ex = 1'b1; hilo_rd_id = 1'b1;
      rd_en_id = 2'b01; rd_addr_id[4:0] = 5'd5;
      rw_ex = 5'd5; din_sel_ex = 3'b110; alu_r_ex = 32'h11;
      expectOutput("rst_fwd", 1, 32'h11, 0, 0, 1'b0, 1'b0);

      applyStimulus();
      rst = 1'b1;
      expectOutput("rst_start_ignored", 0, 0, 0, 0, 1'b0, 1'b0);

      // EX beats MEM on the same register; port1 has no match.
      applyStimulus();
      rd_en_id = 2'b11; rd_addr_id[4:0] = 5'd5; rd_addr_id[9:5] = 5'd9;
      rw_ex = 5'd5; din_sel_ex = 3'b110; alu_r_ex = 32'h11;
      rw_mem = 5'd5; din_sel_mem = 3'b110; alu_r_mem = 32'h22;
      expectOutput("ex_over_mem", 1, 32'h11, 1, RD1, 1'b0, 1'b0);

      // MEM ALU on port0, EX cp0 on port1.
      applyStimulus();
      rd_en_id = 2'b11; rd_addr_id[4:0] = 5'd5; rd_addr_id[9:5] = 5'd6;
      rw_ex = 5'd6; din_sel_ex = 3'b011; cp0_ex = 32'h0000_C0E0;
      rw_mem = 5'd5; din_sel_mem = 3'b110; alu_r_mem = 32'h22;
      expectOutput("mem_alu_ex_cp0", 1, 32'h22, 1, 32'h0000_C0E0, 1'b0, 1'b0);

      // r0 is never forwarded; disabled port passes register data.
      applyStimulus();
      rd_en_id = 2'b10;
      rw_ex = 5'd0; din_sel_ex = 3'b110; alu_r_ex = 32'h11;
      rw_mem = 5'd0; din_sel_mem = 3'b110;
      expectOutput("r0_no_fwd", 1, RD0, 1, RD1, 1'b0, 1'b0);

      // pc+8 from MEM, HI from EX.
      applyStimulus();
      rd_en_id = 2'b11; rd_addr_id[4:0] = 5'd7; rd_addr_id[9:5] = 5'd8;
      rw_mem = 5'd7; din_sel_mem = 3'b001; pc_mem = 32'h400;
      rw_ex = 5'd8; din_sel_ex = 3'b100; hilo_ex = {32'h1111_AAAA, 32'h2222_BBBB};
      expectOutput("pc8_hi", 1, 32'h408, 1, 32'h1111_AAAA, 1'b0, 1'b0);

      // Invalid EX code falls through to MEM LO; port1 disabled.
      applyStimulus();
      rd_en_id = 2'b01; rd_addr_id[4:0] = 5'd4; rd_addr_id[9:5] = 5'd4;
      rw_ex = 5'd4; din_sel_ex = 3'b111; alu_r_ex = 32'h11;
      rw_mem = 5'd4; din_sel_mem = 3'b101; hilo_mem = {32'h3333_CCCC, 32'h4444_DDDD};
      expectOutput("bad_code_mem_lo", 1, 32'h4444_DDDD, 1, RD1, 1'b0, 1'b0);

      // Load-use with the load in EX.
      applyStimulus();
      rd_en_id = 2'b01; rd_addr_id[4:0] = 5'd3;
      rw_ex = 5'd3; din_sel_ex = 3'b010;
      expectOutput("load_use_ex", 0, 0, 0, 0, 1'b1, 1'b0);

      // Same load now in MEM.
      applyStimulus();
      rd_en_id = 2'b01; rd_addr_id[4:0] = 5'd3;
      rw_mem = 5'd3; din_sel_mem = 3'b010; dmout_mem = 32'hAB;
`ifdef FWD_DMOUT_EN
      expectOutput("load_mem_fwd", 1, 32'hAB, 0, 0, 1'b0, 1'b0);
`else
      expectOutput("load_mem_stall", 0, 0, 0, 0, 1'b1, 1'b0);
`endif

      // md start with HI/LO read and a simultaneous load-use: one stall.
      applyStimulus();
      md_start_ex = 1'b1; hilo_rd_id = 1'b1;
      rd_en_id = 2'b01; rd_addr_id[4:0] = 5'd3;
      rw_ex = 5'd3; din_sel_ex = 3'b010;
      expectOutput("md_start_stall", 0, 0, 0, 0, 1'b1, 1'b0);

      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         hilo_rd_id = 1'b1;
         expectOutput("md_busy_stall", 0, 0, 0, 0, 1'b1, 1'b1);
      end

      applyStimulus();
      hilo_rd_id = 1'b1;
      expectOutput("md_done", 0, 0, 0, 0, 1'b0, 1'b0);

      // Reset mid-countdown (count at 2 during the reset cycle).
      applyStimulus();
      md_start_ex = 1'b1;
      expectOutput("md_start_no_read", 0, 0, 0, 0, 1'b0, 1'b0);
      applyStimulus();
      expectOutput("md_cnt4", 0, 0, 0, 0, 1'b0, 1'b1);
      applyStimulus();
      expectOutput("md_cnt3", 0, 0, 0, 0, 1'b0, 1'b1);
      applyStimulus();
      rst = 1'b1; md_start_ex = 1'b1; hilo_rd_id = 1'b1;
      expectOutput("rst_mid_count", 0, 0, 0, 0, 1'b0, 1'b1);
      applyStimulus();
      expectOutput("after_rst", 0, 0, 0, 0, 1'b0, 1'b0);

      // Restart while busy reloads the full latency.
      applyStimulus();
      md_start_ex = 1'b1;
      expectOutput("restart_a", 0, 0, 0, 0, 1'b0, 1'b0);
      applyStimulus();
      expectOutput("restart_cnt4", 0, 0, 0, 0, 1'b0, 1'b1);
      applyStimulus();
      expectOutput("restart_cnt3", 0, 0, 0, 0, 1'b0, 1'b1);
      applyStimulus();
      md_start_ex = 1'b1;
      expectOutput("restart_b", 0, 0, 0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         expectOutput("reloaded_busy", 0, 0, 0, 0, 1'b0, 1'b1);
      end
      applyStimulus();
      expectOutput("reloaded_done", 0, 0, 0, 0, 1'b0, 1'b0);

      applyStimulus();
      @(negedge clk);
      #1;
      checkOutput("scoreboard", "pending", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
